// File: rtl/matrix_port_arbiter.sv
// matrix_port_arbiter: shares one single-write-port, combinational-read
// register matrix between two requesters. After reset every entry is swept
// to INIT_DATA; afterwards requests are granted round-robin, one at a time,
// and each access returns the entry's contents as they were before it.
//
// Handshake: a request transfers in the cycle where reqN_valid and
// reqN_ready are both high (ready is only raised in IDLE for the granted
// requester, and fields are sampled only in that cycle). A response
// transfers in the cycle where rspN_valid and rspN_ready are both high;
// rspN_valid and rspN_rdata hold steady until then.
module matrix_port_arbiter #(
   parameter int                  DATA_LEN  = 32,
   parameter int                  ADDR_LEN  = 5,
   parameter logic [DATA_LEN-1:0] INIT_DATA = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic                req0_we,
   input  logic [ADDR_LEN-1:0] req0_addr,
   input  logic [DATA_LEN-1:0] req0_wdata,
   output logic                rsp0_valid,
   input  logic                rsp0_ready,
   output logic [DATA_LEN-1:0] rsp0_rdata,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic                req1_we,
   input  logic [ADDR_LEN-1:0] req1_addr,
   input  logic [DATA_LEN-1:0] req1_wdata,
   output logic                rsp1_valid,
   input  logic                rsp1_ready,
   output logic [DATA_LEN-1:0] rsp1_rdata,
   output logic                m_wen,
   output logic [ADDR_LEN-1:0] m_addr,
   output logic [DATA_LEN-1:0] m_wdata,
   input  logic [DATA_LEN-1:0] m_rdata,
   output logic                init_done,
   output logic [1:0]          dbg_state
);

   localparam int ADDR_MAX = 2 ** ADDR_LEN;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_LEN-1:0] r_init_cnt;
   logic                r_prio;
   logic                r_init_done;
   logic                r_rsp0_valid;
   logic                r_rsp1_valid;
   logic [DATA_LEN-1:0] r_rsp0_rdata;
   logic [DATA_LEN-1:0] r_rsp1_rdata;

   logic                w_init_last;
   logic                w_gnt;
   logic                w_gnt_id;
   logic                w_rsp_accept;

   assign w_init_last = (r_init_cnt == ADDR_LEN'(ADDR_MAX - 1));

   // Next state, grant selection and matrix port drive; all idle by default.
   always_comb begin
      w_next_state = r_state;
      w_gnt        = 1'b0;
      w_gnt_id     = 1'b0;
      w_rsp_accept = 1'b0;
      m_wen        = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (r_state)
         ST_INIT: begin
            m_wen   = 1'b1;
            m_addr  = r_init_cnt;
            m_wdata = INIT_DATA;
            if (w_init_last) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (req0_valid || req1_valid) begin
               w_gnt = 1'b1;
               // On contention prio decides; otherwise the lone requester wins.
               w_gnt_id = (req0_valid && req1_valid) ? r_prio : req1_valid;
               if (w_gnt_id) begin
                  req1_ready = 1'b1;
                  m_addr     = req1_addr;
                  m_wen      = req1_we;
                  m_wdata    = req1_wdata;
               end else begin
                  req0_ready = 1'b1;
                  m_addr     = req0_addr;
                  m_wen      = req0_we;
                  m_wdata    = req0_wdata;
               end
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            // Only the owner of the outstanding response can retire it.
            w_rsp_accept = r_rsp1_valid ? rsp1_ready : rsp0_ready;
            if (w_rsp_accept) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_INIT;
         end
      endcase
   end

   // State, sweep counter, priority and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_INIT;
         r_init_cnt   <= '0;
         r_prio       <= 1'b0;
         r_init_done  <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_rdata <= '0;
         r_rsp1_rdata <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (w_init_last) begin
               r_init_done <= 1'b1;
            end
         end
         if (w_gnt) begin
            // m_rdata still shows the pre-write contents in the grant cycle.
            if (w_gnt_id) begin
               r_rsp1_rdata <= m_rdata;
               r_rsp1_valid <= 1'b1;
            end else begin
               r_rsp0_rdata <= m_rdata;
               r_rsp0_valid <= 1'b1;
            end
            r_prio <= ~w_gnt_id;
         end
         if (w_rsp_accept) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
         end
      end
   end

   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_rdata = r_rsp0_rdata;
   assign rsp1_rdata = r_rsp1_rdata;
   assign init_done  = r_init_done;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_matrix_port_arbiter.sv
// Testbench for matrix_port_arbiter: small 4-entry matrix, directed
// scenarios plus a randomized run checked against a behavioural model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_matrix_port_arbiter;

   localparam int             DW   = 16;
   localparam int             AW   = 2;
   localparam logic [DW-1:0]  INIT = 16'h00A5;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req0_we;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          rsp0_valid, rsp0_ready;
   logic [DW-1:0] rsp0_rdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          rsp1_valid, rsp1_ready;
   logic [DW-1:0] rsp1_rdata;
   logic          m_wen;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          init_done;
   logic [1:0]    dbg_state;

   int total = 0;
   int bad   = 0;

   // Matrix storage seen by the DUT, and the bench's own view of its contents.
   logic [DW-1:0] mat     [4];
   logic [DW-1:0] ref_mem [4];
   logic          ref_prio;

   matrix_port_arbiter #(.DATA_LEN(DW), .ADDR_LEN(AW), .INIT_DATA(INIT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
      .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .init_done(init_done), .dbg_state(dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Single-write-port, combinational-read matrix.
   always @(posedge clk) if (m_wen) mat[m_addr] <= m_wdata;
   assign m_rdata = mat[m_addr];

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
   endtask

   task automatic drive_req(input int id, input logic valid, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (id == 0) begin
         req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = data;
      end else begin
         req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = data;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      for (int i = 0; i < 4; i++) mat[i] = 16'hDEAD;
      repeat (2) tick();
      #1;
      total++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || init_done !== 1'b0 ||
          rsp0_rdata !== '0 || rsp1_rdata !== '0)
      begin
         bad++;
         $display("FAIL reset_state: rsp0_valid=%b rsp1_valid=%b init_done=%b rdata0=%h rdata1=%h, want all 0",
                  rsp0_valid, rsp1_valid, init_done, rsp0_rdata, rsp1_rdata);
      end
      tick();
      rst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (m_wen !== 1'b1 || m_addr !== AW'(i) || m_wdata !== INIT ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0 || init_done !== 1'b0)
         begin
            bad++;
            $display("FAIL init_sweep[%0d]: wen=%b addr=%0d wdata=%h rdy=%b%b done=%b, want 1 %0d %h 00 0",
                     i, m_wen, m_addr, m_wdata, req0_ready, req1_ready, init_done, i, INIT);
         end
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      total++;
      if (init_done !== 1'b1 || m_wen !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         bad++;
         $display("FAIL init_done_rise: done=%b wen=%b rdy=%b%b, want 1 0 00",
                  init_done, m_wen, req0_ready, req1_ready);
      end
      for (int i = 0; i < 4; i++) ref_mem[i] = INIT;
      ref_prio = 1'b0;
      tick();
   endtask

   task automatic test_contention;
      logic          we   [2];
      logic [AW-1:0] addr [2];
      logic [DW-1:0] data [2];
      logic [DW-1:0] exp_old;
      int            g;
      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < 2; r++) begin
            we[r]   = 1'($urandom_range(0, 1));
            addr[r] = AW'($urandom_range(0, 2));
            data[r] = DW'($urandom);
            drive_req(r, 1'b1, we[r], addr[r], data[r]);
         end
         #1;
         g = int'(ref_prio);
         total++;
         if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || m_addr !== addr[g] ||
             m_wen !== we[g] || m_wdata !== data[g])
         begin
            bad++;
            $display("FAIL contention_grant[%0d]: rdy=%b%b addr=%0d wen=%b wdata=%h, want grant %0d addr=%0d wen=%b wdata=%h",
                     k, req1_ready, req0_ready, m_addr, m_wen, m_wdata, g, addr[g], we[g], data[g]);
         end
         exp_old = ref_mem[addr[g]];
         if (we[g]) ref_mem[addr[g]] = data[g];
         ref_prio = (g == 0);
         tick();
         #1;
         total++;
         if (((g == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 ||
             ((g == 0) ? rsp1_valid : rsp0_valid) !== 1'b0 ||
             ((g == 0) ? rsp0_rdata : rsp1_rdata) !== exp_old ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0 || m_wen !== 1'b0)
         begin
            bad++;
            $display("FAIL contention_rsp[%0d]: rsp_valid=%b%b rdata0=%h rdata1=%h rdy=%b%b wen=%b, want owner %0d data %h",
                     k, rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata, req1_ready, req0_ready, m_wen, g, exp_old);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_write_read;
      drive_req(0, 1'b1, 1'b1, 2'd3, 16'h1234);
      #1;
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || m_wen !== 1'b1 ||
          m_addr !== 2'd3 || m_wdata !== 16'h1234)
      begin
         bad++;
         $display("FAIL write_grant: rdy0=%b rdy1=%b wen=%b addr=%0d wdata=%h, want 1 0 1 3 1234",
                  req0_ready, req1_ready, m_wen, m_addr, m_wdata);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      total++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== 16'h00A5 || rsp1_valid !== 1'b0) begin
         bad++;
         $display("FAIL write_rsp: rsp0_valid=%b rdata=%h rsp1_valid=%b, want 1 00a5 0",
                  rsp0_valid, rsp0_rdata, rsp1_valid);
      end
      tick();
      drive_req(0, 1'b1, 1'b0, 2'd3, 16'h0000);
      #1;
      total++;
      if (req0_ready !== 1'b1 || m_wen !== 1'b0 || m_addr !== 2'd3) begin
         bad++;
         $display("FAIL read_grant: rdy0=%b wen=%b addr=%0d, want 1 0 3", req0_ready, m_wen, m_addr);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      total++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== 16'h1234) begin
         bad++;
         $display("FAIL read_rsp: rsp0_valid=%b rdata=%h, want 1 1234", rsp0_valid, rsp0_rdata);
      end
      tick();
      ref_mem[3] = 16'h1234;
      ref_prio = 1'b1;
   endtask

   task automatic test_backpressure;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_old;
      a = AW'($urandom_range(0, 3));
      d = DW'($urandom);
      drive_req(1, 1'b1, 1'b1, a, d);
      #1;
      total++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || m_addr !== a || m_wen !== 1'b1) begin
         bad++;
         $display("FAIL bp_grant: rdy1=%b rdy0=%b addr=%0d wen=%b, want 1 0 %0d 1",
                  req1_ready, req0_ready, m_addr, m_wen, a);
      end
      exp_old = ref_mem[a];
      ref_mem[a] = d;
      tick();
      req1_valid = 1'b0;
      rsp1_ready = 1'b0;
      drive_req(0, 1'b1, 1'b0, 2'd3, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         if (i == 5) rsp1_ready = 1'b1;
         #1;
         total++;
         if (rsp1_valid !== 1'b1 || rsp1_rdata !== exp_old || rsp0_valid !== 1'b0 ||
             req0_ready !== 1'b0 || m_wen !== 1'b0)
         begin
            bad++;
            $display("FAIL bp_hold[%0d]: rsp1_valid=%b rdata=%h rsp0_valid=%b rdy0=%b wen=%b, want 1 %h 0 0 0",
                     i, rsp1_valid, rsp1_rdata, rsp0_valid, req0_ready, m_wen, exp_old);
         end
         tick();
      end
      #1;
      total++;
      if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0 || m_addr !== 2'd3) begin
         bad++;
         $display("FAIL bp_resume: rdy0=%b rsp1_valid=%b addr=%0d, want 1 0 3",
                  req0_ready, rsp1_valid, m_addr);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      total++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== ref_mem[3]) begin
         bad++;
         $display("FAIL bp_rsp0: rsp0_valid=%b rdata=%h, want 1 %h", rsp0_valid, rsp0_rdata, ref_mem[3]);
      end
      tick();
      ref_prio = 1'b1;
   endtask

   task automatic test_lone_req1;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_old;
      for (int k = 0; k < 3; k++) begin
         we = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 3));
         d  = DW'($urandom);
         drive_req(1, 1'b1, we, a, d);
         #1;
         total++;
         if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || m_addr !== a || m_wen !== we) begin
            bad++;
            $display("FAIL lone1_grant[%0d]: rdy1=%b rdy0=%b addr=%0d wen=%b, want 1 0 %0d %b",
                     k, req1_ready, req0_ready, m_addr, m_wen, a, we);
         end
         exp_old = ref_mem[a];
         if (we) ref_mem[a] = d;
         tick();
         #1;
         total++;
         if (rsp1_valid !== 1'b1 || rsp1_rdata !== exp_old || rsp0_valid !== 1'b0) begin
            bad++;
            $display("FAIL lone1_rsp[%0d]: rsp1_valid=%b rdata=%h rsp0_valid=%b, want 1 %h 0",
                     k, rsp1_valid, rsp1_rdata, rsp0_valid, exp_old);
         end
         tick();
      end
      idle_inputs();
      ref_prio = 1'b0;
   endtask

   task automatic test_random;
      logic          ref_busy;
      logic          ref_owner;
      logic [DW-1:0] ref_data;
      int            e_gnt;
      logic          e_wen;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      ref_busy  = 1'b0;
      ref_owner = 1'b0;
      ref_data  = '0;
      for (int c = 0; c < 300; c++) begin
         drive_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 3)), DW'($urandom));
         drive_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 3)), DW'($urandom));
         rsp0_ready = ($urandom_range(0, 3) != 0);
         rsp1_ready = ($urandom_range(0, 3) != 0);
         #1;
         e_gnt = -1;
         if (!ref_busy) begin
            if (req0_valid && req1_valid) e_gnt = int'(ref_prio);
            else if (req0_valid)          e_gnt = 0;
            else if (req1_valid)          e_gnt = 1;
         end
         e_wen   = (e_gnt == 0) ? req0_we    : (e_gnt == 1) ? req1_we    : 1'b0;
         e_addr  = (e_gnt == 0) ? req0_addr  : (e_gnt == 1) ? req1_addr  : '0;
         e_wdata = (e_gnt == 0) ? req0_wdata : (e_gnt == 1) ? req1_wdata : '0;
         total++;
         if (req0_ready !== (e_gnt == 0) || req1_ready !== (e_gnt == 1) || m_wen !== e_wen ||
             m_addr !== e_addr || m_wdata !== e_wdata)
         begin
            bad++;
            $display("FAIL rand_port[%0d]: rdy=%b%b wen=%b addr=%0d wdata=%h, want grant %0d wen=%b addr=%0d wdata=%h",
                     c, req1_ready, req0_ready, m_wen, m_addr, m_wdata, e_gnt, e_wen, e_addr, e_wdata);
         end
         total++;
         if (rsp0_valid !== (ref_busy && !ref_owner) || rsp1_valid !== (ref_busy && ref_owner) ||
             (ref_busy && (ref_owner ? rsp1_rdata : rsp0_rdata) !== ref_data))
         begin
            bad++;
            $display("FAIL rand_rsp[%0d]: rsp_valid=%b%b rdata0=%h rdata1=%h, want busy=%b owner=%b data=%h",
                     c, rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata, ref_busy, ref_owner, ref_data);
         end
         if (e_gnt >= 0) begin
            ref_data = ref_mem[e_addr];
            if (e_wen) ref_mem[e_addr] = e_wdata;
            ref_busy  = 1'b1;
            ref_owner = (e_gnt == 1);
            ref_prio  = (e_gnt == 0);
         end else if (ref_busy && (ref_owner ? rsp1_ready : rsp0_ready)) begin
            ref_busy = 1'b0;
         end
         tick();
      end
      idle_inputs();
      repeat (2) tick();
   endtask

   task automatic test_reset_mid;
      rsp0_ready = 1'b0;
      drive_req(0, 1'b1, 1'b0, AW'($urandom_range(0, 3)), 16'h0000);
      tick();
      req0_valid = 1'b0;
      #1;
      total++;
      if (rsp0_valid !== 1'b1) begin
         bad++;
         $display("FAIL midrst_pre: rsp0_valid=%b, want 1", rsp0_valid);
      end
      rst = 1'b1;
      tick();
      #1;
      total++;
      if (rsp0_valid !== 1'b0 || init_done !== 1'b0 || m_wen !== 1'b1 || m_addr !== '0) begin
         bad++;
         $display("FAIL midrst_after: rsp0_valid=%b done=%b wen=%b addr=%0d, want 0 0 1 0",
                  rsp0_valid, init_done, m_wen, m_addr);
      end
      rst = 1'b0;
      rsp0_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (m_wen !== 1'b1 || m_addr !== AW'(i) || init_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_sweep[%0d]: wen=%b addr=%0d done=%b, want 1 %0d 0",
                     i, m_wen, m_addr, init_done, i);
         end
         tick();
      end
      #1;
      total++;
      if (init_done !== 1'b1 || m_wen !== 1'b0) begin
         bad++;
         $display("FAIL midrst_done: done=%b wen=%b, want 1 0", init_done, m_wen);
      end
      tick();
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   // Test sequence and final report.
   initial begin
      test_reset();
      test_contention();
      test_write_read();
      test_backpressure();
      test_lone_req1();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
